// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the data-memory access engine.
//   mem_ctrl_t : decoded view of the 5-bit memory control field
//                {valid, store, size[1:0], zext}
//   SZ_*       : access size encodings (2'b10 is illegal and handled as word)
//   state_t    : access FSM states
//   is_misaligned() : address-error check shared by load and store paths
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef struct packed {
        logic       valid;
        logic       store;
        logic [1:0] size;
        logic       zext;
    } mem_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bytes never fault; halves need addr[0]==0; words (and the illegal
    // size encoding, which behaves as a word) need addr[1:0]==0.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Purely combinational lane logic for one memory access.
//   size       in  2   access size (SZ_BYTE / SZ_HALF / word otherwise)
//   zext       in  1   1 = zero-extend loads, 0 = sign-extend
//   addr_lo    in  2   low address bits selecting the byte lane
//   wdata      in  32  right-justified store data
//   rdata      in  32  raw bus read word
//   wstrb      out 4   byte enables for the store
//   wdata_lane out 32  store data replicated across all lanes
//   rdata_ext  out 32  selected load lane, shifted down and extended
// -----------------------------------------------------------------------------
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = rdata[7:0];
        case (addr_lo)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        case (size)
            SZ_BYTE: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = zext ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = zext ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            default: begin
                wstrb      = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Runs one load or store per request on a req/ack data bus for the MEM stage,
// holding the pipeline stalled while the bus transfer is outstanding.
//   clk, reset             clock, synchronous active-high reset
//   start, mem_ctrl        launch request and its {valid,store,size,zext} field
//   addr, wdata_in         effective address, right-justified store data
//   flush                  discard the current / pending result
//   bus_req .. bus_wdata   bus request side (address word-aligned)
//   bus_rdata, bus_ack     bus response side
//   stall                  high while a bus transfer is outstanding
//   done                   one-cycle completion pulse
//   rdata_out              extended load result, held between completions
//   exc_adel/exc_ades      load/store address error, valid with done
//   badvaddr               faulting address, valid with done
//   dbg_state              current FSM state (state_t encoding)
//
// Bus handshake: once bus_req rises, bus_req and every bus output stay
// stable until the cycle in which bus_ack is sampled high; the transfer
// completes on that edge. A request is never withdrawn except by reset,
// and bus_ack is ignored whenever bus_req is low.
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        mem_ctrl,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              flush,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [DATA_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata_out,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic [DATA_W-1:0] badvaddr,
    output logic [1:0]        dbg_state
);

    mem_ctrl_t         ctrl_in;
    state_t            state_q, state_d;
    logic              store_q, store_d;
    logic [1:0]        size_q, size_d;
    logic              zext_q, zext_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              flushed_q, flushed_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              adel_q, adel_d;
    logic              ades_q, ades_d;
    logic [DATA_W-1:0] badvaddr_q, badvaddr_d;

    logic [3:0]        lane_strb;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] load_ext;

    assign ctrl_in = mem_ctrl_t'(mem_ctrl);

    mem_align u_align (
        .size       (size_q),
        .zext       (zext_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (bus_rdata),
        .wstrb      (lane_strb),
        .wdata_lane (lane_wdata),
        .rdata_ext  (load_ext)
    );

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        size_d     = size_q;
        zext_d     = zext_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        flushed_d  = flushed_q;
        rdata_d    = rdata_q;
        adel_d     = adel_q;
        ades_d     = ades_q;
        badvaddr_d = badvaddr_q;
        case (state_q)
            ST_IDLE: begin
                flushed_d = 1'b0;
                adel_d    = 1'b0;
                ades_d    = 1'b0;
                if (start && ctrl_in.valid && !flush) begin
                    store_d = ctrl_in.store;
                    size_d  = ctrl_in.size;
                    zext_d  = ctrl_in.zext;
                    addr_d  = addr;
                    wdata_d = wdata_in;
                    if (is_misaligned(ctrl_in.size, addr[1:0])) begin
                        // Address errors complete without touching the bus.
                        state_d    = ST_DONE;
                        adel_d     = !ctrl_in.store;
                        ades_d     = ctrl_in.store;
                        badvaddr_d = addr;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // A flush cannot cancel the bus request; remember it so the
                // eventual completion is swallowed.
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (bus_ack) begin
                    state_d = ST_DONE;
                    if (!store_q && !flushed_q && !flush) begin
                        rdata_d = load_ext;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                flushed_d = 1'b0;
                adel_d    = 1'b0;
                ades_d    = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            store_q    <= 1'b0;
            size_q     <= SZ_BYTE;
            zext_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            flushed_q  <= 1'b0;
            rdata_q    <= '0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            badvaddr_q <= '0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            size_q     <= size_d;
            zext_q     <= zext_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            flushed_q  <= flushed_d;
            rdata_q    <= rdata_d;
            adel_q     <= adel_d;
            ades_q     <= ades_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // Bus outputs are quiet outside REQ; strobes and write data only on writes.
    assign bus_req   = (state_q == ST_REQ);
    assign bus_wr    = bus_req && store_q;
    assign bus_addr  = bus_req ? {addr_q[DATA_W-1:2], 2'b00} : '0;
    assign bus_wstrb = bus_wr ? lane_strb : 4'b0000;
    assign bus_wdata = bus_wr ? lane_wdata : '0;

    assign stall     = (state_q == ST_REQ);
    // Flush during the DONE cycle itself must also hide the completion.
    assign done      = (state_q == ST_DONE) && !flushed_q && !flush;
    assign exc_adel  = adel_q && done;
    assign exc_ades  = ades_q && done;
    assign rdata_out = rdata_q;
    assign badvaddr  = badvaddr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed vectors for mem_access_unit. Expected completions and expected bus
// requests are queued when each vector is issued; two monitors pop and compare
// whenever the DUT shows done or bus_req.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  mem_ctrl;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic        flush;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall;
    logic        done;
    logic [31:0] rdata_out;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] badvaddr;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // {adel, ades, badvaddr, rdata_out}
    logic [65:0] exp_q[$];
    // {wr, addr, wstrb, wdata}
    logic [68:0] bus_q[$];
    logic [65:0] res_e;
    logic [68:0] bus_e;
    logic        bus_seen = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_ctrl  (mem_ctrl),
        .addr      (addr),
        .wdata_in  (wdata_in),
        .flush     (flush),
        .bus_req   (bus_req),
        .bus_wr    (bus_wr),
        .bus_addr  (bus_addr),
        .bus_wstrb (bus_wstrb),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .stall     (stall),
        .done      (done),
        .rdata_out (rdata_out),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .badvaddr  (badvaddr),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_res(input logic adel, input logic ades,
                            input logic [31:0] bad, input logic [31:0] rd);
        exp_q.push_back({adel, ades, bad, rd});
    endtask

    task automatic push_bus(input logic wr, input logic [31:0] a,
                            input logic [3:0] strb, input logic [31:0] wd);
        bus_q.push_back({wr, a, strb, wd});
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 rdata=%h expected no completion", rdata_out);
            end else begin
                res_e = exp_q.pop_front();
                check("result_exc", 69'({exc_adel, exc_ades}), 69'(res_e[65:64]));
                check("result_rdata", 69'(rdata_out), 69'(res_e[31:0]));
                if (res_e[65] || res_e[64]) begin
                    check("result_badvaddr", 69'(badvaddr), 69'(res_e[63:32]));
                end
            end
        end else if (exc_adel || exc_ades) begin
            n_vec++;
            n_err++;
            $display("FAIL exc_without_done: got adel=%0b ades=%0b expected 0 0", exc_adel, exc_ades);
        end
    end

    always @(negedge clk) begin
        if (bus_req) begin
            if (!bus_seen) begin
                bus_seen = 1'b1;
                if (bus_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_bus_req: got addr=%h wr=%0b expected no request", bus_addr, bus_wr);
                    bus_e = {bus_wr, bus_addr, bus_wstrb, bus_wdata};
                end else begin
                    bus_e = bus_q.pop_front();
                    check("bus_fields", {bus_wr, bus_addr, bus_wstrb, bus_wdata}, bus_e);
                end
            end else begin
                check("bus_held", {bus_wr, bus_addr, bus_wstrb, bus_wdata}, bus_e);
            end
        end else begin
            bus_seen = 1'b0;
        end
    end

    // ---------------- driver ----------------
    // ack_dly: REQ cycles before the ack cycle; flush_at: REQ cycle (1-based)
    // carrying flush, 0 for none; flush_done: flush during the DONE cycle.
    task automatic op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int ack_dly, input int flush_at,
                      input bit misal, input bit flush_done);
        logic exp_done;
        exp_done = !((flush_at > 0) || flush_done);
        @(posedge clk); #1;
        start    = 1'b1;
        mem_ctrl = ctrl;
        addr     = a;
        wdata_in = wd;
        @(posedge clk); #1;
        start    = 1'b0;
        mem_ctrl = 5'd0;
        addr     = 32'd0;
        wdata_in = 32'd0;
        if (!misal) begin
            for (int i = 1; i <= ack_dly + 1; i++) begin
                flush     = (i == flush_at);
                bus_ack   = (i == ack_dly + 1);
                bus_rdata = (i == ack_dly + 1) ? rd : $urandom;
                @(negedge clk);
                check("req_stall", 69'({bus_req, stall}), 69'(2'b11));
                @(posedge clk); #1;
            end
            bus_ack   = 1'b0;
            bus_rdata = 32'd0;
        end
        flush = flush_done;
        @(negedge clk);
        check("done_pulse", 69'({done, stall}), 69'({exp_done, 1'b0}));
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("back_to_idle", 69'({done, stall, dbg_state}), 69'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        mem_ctrl  = 5'd0;
        addr      = 32'd0;
        wdata_in  = 32'd0;
        flush     = 1'b0;
        bus_rdata = 32'd0;
        bus_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_bus", 69'({bus_req, bus_wr, bus_wstrb, bus_addr}), 69'(0));
        check("reset_bus_wdata", 69'(bus_wdata), 69'(0));
        check("reset_status", 69'({stall, done, exc_adel, exc_ades, dbg_state}), 69'(0));
        check("reset_rdata", 69'(rdata_out), 69'(0));
        check("reset_badvaddr", 69'(badvaddr), 69'(0));

        // LB sign-extend, lane 3
        push_bus(1'b0, 32'h0000_1000, 4'h0, 32'h0);
        push_res(1'b0, 1'b0, 32'h0, 32'hFFFF_FF80);
        op(5'b10000, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 1, 0, 1'b0, 1'b0);
        // LHU upper half
        push_bus(1'b0, 32'h0000_2000, 4'h0, 32'h0);
        push_res(1'b0, 1'b0, 32'h0, 32'h0000_9ABC);
        op(5'b10011, 32'h0000_2002, 32'h0, 32'h9ABC_1234, 0, 0, 1'b0, 1'b0);
        // SB lane 0
        push_bus(1'b1, 32'h0000_0010, 4'b0001, 32'h5555_5555);
        push_res(1'b0, 1'b0, 32'h0, 32'h0000_9ABC);
        op(5'b11000, 32'h0000_0010, 32'h0000_0055, 32'h0, 2, 0, 1'b0, 1'b0);
        // SH upper half
        push_bus(1'b1, 32'h0000_0010, 4'b1100, 32'hBEEF_BEEF);
        push_res(1'b0, 1'b0, 32'h0, 32'h0000_9ABC);
        op(5'b11010, 32'h0000_0012, 32'h0000_BEEF, 32'h0, 0, 0, 1'b0, 1'b0);
        // LW misaligned -> AdEL, no bus
        push_res(1'b1, 1'b0, 32'h0000_1002, 32'h0000_9ABC);
        op(5'b10110, 32'h0000_1002, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0);
        // SW misaligned -> AdES, no bus
        push_res(1'b0, 1'b1, 32'h0000_1001, 32'h0000_9ABC);
        op(5'b11110, 32'h0000_1001, 32'h0000_CAFE, 32'h0, 0, 0, 1'b1, 1'b0);
        // LBU lane 1 with top bit set, ack in first REQ cycle
        push_bus(1'b0, 32'h0000_1000, 4'h0, 32'h0);
        push_res(1'b0, 1'b0, 32'h0, 32'h0000_0080);
        op(5'b10001, 32'h0000_1001, 32'h0, 32'h1234_8056, 0, 0, 1'b0, 1'b0);
        // LH sign-extend lower half
        push_bus(1'b0, 32'h0000_4000, 4'h0, 32'h0);
        push_res(1'b0, 1'b0, 32'h0, 32'hFFFF_8001);
        op(5'b10010, 32'h0000_4000, 32'h0, 32'h0000_8001, 2, 0, 1'b0, 1'b0);
        // LW aligned
        push_bus(1'b0, 32'h0000_3000, 4'h0, 32'h0);
        push_res(1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
        op(5'b10110, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 1, 0, 1'b0, 1'b0);
        // LW with ack after 5 cycles, flush in REQ cycle 2: swallowed
        push_bus(1'b0, 32'h0000_3004, 4'h0, 32'h0);
        op(5'b10110, 32'h0000_3004, 32'h0, 32'h1111_1111, 5, 2, 1'b0, 1'b0);
        check("flush_rdata_kept", 69'(rdata_out), 69'(32'hDEAD_BEEF));
        // SB lane 3, upper store bits must not leak
        push_bus(1'b1, 32'h0000_0010, 4'b1000, 32'hA7A7_A7A7);
        push_res(1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
        op(5'b11000, 32'h0000_0013, 32'hFFFF_FFA7, 32'h0, 1, 0, 1'b0, 1'b0);
        // Illegal size 2'b10 store behaves as word
        push_bus(1'b1, 32'h0000_0008, 4'b1111, 32'h1234_5678);
        push_res(1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
        op(5'b11100, 32'h0000_0008, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 1'b0);
        // Illegal size 2'b10 load at addr 2 faults as a word
        push_res(1'b1, 1'b0, 32'h0000_0002, 32'hDEAD_BEEF);
        op(5'b10100, 32'h0000_0002, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0);
        // LB positive byte
        push_bus(1'b0, 32'h0000_3004, 4'h0, 32'h0);
        push_res(1'b0, 1'b0, 32'h0, 32'h0000_007F);
        op(5'b10000, 32'h0000_3005, 32'h0, 32'h0000_7F00, 0, 0, 1'b0, 1'b0);
        // Misaligned LH with flush in DONE: nothing reported
        op(5'b10010, 32'h0000_0003, 32'h0, 32'h0, 0, 0, 1'b1, 1'b1);
        // LH sign-extend upper half
        push_bus(1'b0, 32'h0000_0000, 4'h0, 32'h0);
        push_res(1'b0, 1'b0, 32'h0, 32'hFFFF_F00D);
        op(5'b10010, 32'h0000_0002, 32'h0, 32'hF00D_0000, 3, 0, 1'b0, 1'b0);

        // Flush in IDLE blocks acceptance
        @(posedge clk); #1;
        start = 1'b1; mem_ctrl = 5'b10110; addr = 32'h0000_0100; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mem_ctrl = 5'd0; addr = 32'd0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush_block", 69'({bus_req, stall, done, dbg_state}), 69'(0));
        // start with valid=0 is not a memory op
        @(posedge clk); #1;
        start = 1'b1; mem_ctrl = 5'b00110; addr = 32'h0000_0001;
        @(posedge clk); #1;
        start = 1'b0; mem_ctrl = 5'd0; addr = 32'd0;
        @(negedge clk);
        check("invalid_ignored", 69'({bus_req, stall, done, dbg_state}), 69'(0));

        // Reset while in REQ abandons the request
        push_bus(1'b0, 32'h0000_6000, 4'h0, 32'h0);
        @(posedge clk); #1;
        start = 1'b1; mem_ctrl = 5'b10110; addr = 32'h0000_6000;
        @(posedge clk); #1;
        start = 1'b0; mem_ctrl = 5'd0; addr = 32'd0;
        @(negedge clk);
        check("pre_reset_req", 69'({bus_req, stall}), 69'(2'b11));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_idle", 69'({bus_req, stall, done, dbg_state}), 69'(0));
        check("mid_reset_rdata", 69'(rdata_out), 69'(0));
        // Normal operation afterwards
        push_bus(1'b0, 32'h0000_6000, 4'h0, 32'h0);
        push_res(1'b0, 1'b0, 32'h0, 32'h0BAD_F00D);
        op(5'b10110, 32'h0000_6000, 32'h0, 32'h0BAD_F00D, 1, 0, 1'b0, 1'b0);

        // ---------------- final report ----------------
        repeat (3) @(posedge clk);
        check("exp_q_drained", 69'(exp_q.size()), 69'(0));
        check("bus_q_drained", 69'(bus_q.size()), 69'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule
